// File: rtl/psum_row_writeback.sv
// psum_row_writeback: ReLU/shift/saturate each psum, pack PACK lanes per word, queue words for GLB; word visible 1 cycle after its last accept.
// Rdy falls while the word FIFO is full (registered count only); define PSM_ROUND_EN for round-half-up requantisation.

module psm_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         vld,
    output logic         full,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign vld     = (cnt != '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && vld;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module psum_row_writeback #(
    parameter int PSUM_WIDTH  = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int PACK        = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int LENROW      = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SHIFT_WIDTH-1:0]       CFG_Shift,
    input  logic                         CFG_Relu,
    input  logic                         CNVPSM_Vld,
    input  logic signed [PSUM_WIDTH-1:0] CNVPSM_Psum,
    input  logic                         CNVPSM_FnhRow,
    output logic                         PSMCNV_Rdy,
    output logic                         PSMGLB_Vld,
    output logic [DATA_WIDTH*PACK-1:0]   PSMGLB_Dat,
    output logic                         PSMGLB_Last,
    input  logic                         GLBPSM_Rdy,
    output logic                         PSMPEC_Err
);
    localparam int WORD_W = DATA_WIDTH * PACK;
    localparam int LANE_W = $clog2(PACK);
    localparam int ROW_W  = $clog2(LENROW + 1);

    localparam logic signed [PSUM_WIDTH:0] SAT_MAX = (PSUM_WIDTH+1)'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PSUM_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t                      state_q, state_d;
    logic [LANE_W-1:0]           lane_q, lane_d, lane_sel;
    logic [WORD_W-1:0]           pack_q, pack_d, word;
    logic [ROW_W-1:0]            row_q;
    logic                        accept;
    logic                        push;
    logic                        fifo_full;
    logic [WORD_W:0]             fifo_head;

    int                          shift_amt;
    logic signed [PSUM_WIDTH:0]  ext;
    logic signed [PSUM_WIDTH:0]  shifted;
    logic [DATA_WIDTH-1:0]       elem;

    // Rdy looks only at the registered fill level, so a same-cycle pop never reopens a full FIFO.
    assign PSMCNV_Rdy = rst_n && !fifo_full;
    assign accept     = CNVPSM_Vld && PSMCNV_Rdy;

    always_comb begin
        shift_amt = (int'(CFG_Shift) >= PSUM_WIDTH) ? (PSUM_WIDTH - 1) : int'(CFG_Shift);
        ext       = {CNVPSM_Psum[PSUM_WIDTH-1], CNVPSM_Psum};
`ifdef PSM_ROUND_EN
        if (shift_amt > 0) begin
            ext = ext + ((PSUM_WIDTH+1)'(1) << (shift_amt - 1));
        end
`endif
        shifted = ext >>> shift_amt;
        if (CFG_Relu && CNVPSM_Psum[PSUM_WIDTH-1]) begin
            elem = '0;
        end else if (shifted > SAT_MAX) begin
            elem = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            elem = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            elem = shifted[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        pack_d   = pack_q;
        push     = 1'b0;
        lane_sel = (state_q == FILL) ? lane_q : '0;
        word     = pack_q;
        word[int'(lane_sel)*DATA_WIDTH +: DATA_WIDTH] = elem;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (CNVPSM_FnhRow) begin
                        push = 1'b1;
                    end else begin
                        state_d = FILL;
                        lane_d  = LANE_W'(1);
                        pack_d  = word;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (lane_q == LANE_W'(PACK - 1) || CNVPSM_FnhRow) begin
                        push    = 1'b1;
                        state_d = IDLE;
                        lane_d  = '0;
                        pack_d  = '0;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                        pack_d = word;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            pack_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
        end
    end

    // Row length saturates at LENROW; any further element without FnhRow flags the overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q      <= '0;
            PSMPEC_Err <= 1'b0;
        end else if (accept) begin
            if (CNVPSM_FnhRow) begin
                row_q <= '0;
            end else if (row_q == ROW_W'(LENROW)) begin
                PSMPEC_Err <= 1'b1;
            end else begin
                row_q <= row_q + ROW_W'(1);
            end
        end
    end

    psm_fifo #(
        .W     (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({CNVPSM_FnhRow, word}),
        .pop      (GLBPSM_Rdy),
        .vld      (PSMGLB_Vld),
        .full     (fifo_full),
        .head     (fifo_head)
    );

    assign PSMGLB_Dat  = fifo_head[WORD_W-1:0];
    assign PSMGLB_Last = fifo_head[WORD_W];
endmodule

// File: tb/tb_psum_row_writeback.sv
// Directed + randomized bench for psum_row_writeback with a queue-based reference model.
module tb_psum_row_writeback;
    localparam int PW     = 20;
    localparam int DW     = 8;
    localparam int PACK   = 4;
    localparam int DEPTH  = 4;
    localparam int LENROW = 16;

    logic                 clk;
    logic                 rst_n;
    logic [4:0]           shift;
    logic                 relu;
    logic                 vld;
    logic signed [PW-1:0] psum;
    logic                 fnh;
    logic                 cnv_rdy;
    logic                 glb_vld;
    logic [DW*PACK-1:0]   glb_dat;
    logic                 glb_last;
    logic                 glb_rdy;
    logic                 err;

    psum_row_writeback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CFG_Shift     (shift),
        .CFG_Relu      (relu),
        .CNVPSM_Vld    (vld),
        .CNVPSM_Psum   (psum),
        .CNVPSM_FnhRow (fnh),
        .PSMCNV_Rdy    (cnv_rdy),
        .PSMGLB_Vld    (glb_vld),
        .PSMGLB_Dat    (glb_dat),
        .PSMGLB_Last   (glb_last),
        .GLBPSM_Rdy    (glb_rdy),
        .PSMPEC_Err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW*PACK-1:0] dat;
        logic               last;
    } word_t;

    word_t exp_q[$];
    int    cur_lanes[$];
    int    row_len;
    bit    exp_err;
    bit    rand_rdy;
    int    checks;
    int    errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference requantiser: clamp shift, optional round, floor-shift, clip.
    function automatic int requant(input longint p, input int sh, input bit rl);
        longint v;
        int     s;
        if (rl && p < 0) return 0;
        s = (sh >= PW) ? PW - 1 : sh;
        v = p;
`ifdef PSM_ROUND_EN
        if (s > 0) v = v + (longint'(1) << (s - 1));
`endif
        v = v >>> s;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    task automatic model_accept();
        word_t w;
        cur_lanes.push_back(requant(longint'(psum), int'(shift), relu));
        if (!fnh && row_len >= LENROW) exp_err = 1'b1;
        row_len = fnh ? 0 : row_len + 1;
        if (cur_lanes.size() == PACK || fnh) begin
            w.dat = '0;
            for (int i = 0; i < cur_lanes.size(); i++) w.dat[i*DW +: DW] = 8'(cur_lanes[i]);
            w.last = fnh;
            exp_q.push_back(w);
            cur_lanes.delete();
        end
    endtask

    // One clock: compare outputs against the model, then advance both across the edge.
    task automatic tick(output bit acc);
        bit   pop;
        logic exp_rdy;
        #1;
        exp_rdy = (rst_n === 1'b1) && (exp_q.size() < DEPTH);
        chk("cnv_rdy", 64'(cnv_rdy), 64'(exp_rdy));
        chk("glb_vld", 64'(glb_vld), 64'(exp_q.size() != 0));
        chk("err", 64'(err), 64'(exp_err));
        if (exp_q.size() != 0) begin
            chk("glb_dat", 64'(glb_dat), 64'(exp_q[0].dat));
            chk("glb_last", 64'(glb_last), 64'(exp_q[0].last));
        end
        acc = vld && cnv_rdy;
        pop = glb_vld && glb_rdy;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            cur_lanes.delete();
            row_len = 0;
            exp_err = 1'b0;
        end else begin
            if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) model_accept();
        end
        @(negedge clk);
    endtask

    task automatic send(input int p, input bit f);
        bit acc;
        psum = PW'(p);
        fnh  = f;
        vld  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(acc);
            if (acc) begin
                vld = 1'b0;
                return;
            end
            if (rand_rdy) glb_rdy = 1'($urandom_range(0, 1));
        end
        vld = 1'b0;
        errors++;
        $error("FAIL send_timeout: observed no accept expected accept within 200 cycles");
    endtask

    task automatic idle(input int n);
        bit acc;
        vld = 1'b0;
        repeat (n) tick(acc);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic l);
        #1;
        chk({tag, "_vld"}, 64'(glb_vld), 64'(1));
        chk({tag, "_dat"}, 64'(glb_dat), 64'(d));
        chk({tag, "_last"}, 64'(glb_last), 64'(l));
    endtask

    initial begin
        bit acc;
        int n_acc;
        int len;
        checks   = 0;
        errors   = 0;
        row_len  = 0;
        exp_err  = 1'b0;
        rand_rdy = 1'b0;
        rst_n    = 1'b0;
        vld      = 1'b0;
        psum     = '0;
        fnh      = 1'b0;
        shift    = '0;
        relu     = 1'b0;
        glb_rdy  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_vld", 64'(glb_vld), 64'(0));
        chk("rst_dat", 64'(glb_dat), 64'(0));
        chk("rst_last", 64'(glb_last), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_cnv_rdy", 64'(cnv_rdy), 64'(0));
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // Basic pack, latency of one cycle after the 4th accept
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        expect_word("t1", 32'h04030201, 1'b1);
        idle(2);

        // Saturation with and without ReLU
        send(300, 0); send(-300, 0); send(-5, 0); send(7, 1);
        expect_word("t2_norelu", 32'h07FB807F, 1'b1);
        idle(2);
        relu = 1'b1;
        send(300, 0); send(-300, 0); send(-5, 0); send(7, 1);
        expect_word("t2_relu", 32'h0700007F, 1'b1);
        idle(2);
        relu = 1'b0;

        // Shift with single-element rows
        shift = 5'd2;
        send(13, 1);
        expect_word("t3_13", 32'h00000003, 1'b1);
        idle(2);
        send(14, 1);
`ifdef PSM_ROUND_EN
        expect_word("t3_14", 32'h00000004, 1'b1);
`else
        expect_word("t3_14", 32'h00000003, 1'b1);
`endif
        idle(2);
        shift = 5'd0;

        // Backpressure: fill the FIFO, hold, then drain in order
        glb_rdy = 1'b0;
        for (int i = 0; i < 16; i++) send(i + 1, (i % 4) == 3);
        #1;
        chk("t4_full_rdy", 64'(cnv_rdy), 64'(0));
        psum  = PW'(17);
        fnh   = 1'b0;
        vld   = 1'b1;
        n_acc = 0;
        repeat (3) begin
            tick(acc);
            if (acc) n_acc++;
        end
        chk("t4_hold_noacc", 64'(n_acc), 64'(0));
        glb_rdy = 1'b1;
        for (int i = 16; i < 20; i++) send(i + 1, (i % 4) == 3);
        idle(8);
        chk("t4_drained", 64'(exp_q.size()), 64'(0));

        // Row overrun: Err on the cycle after the 17th element
        for (int i = 0; i < 16; i++) send(i, 0);
        #1;
        chk("t5_err_before", 64'(err), 64'(0));
        send(16, 0);
        #1;
        chk("t5_err_after", 64'(err), 64'(1));
        idle(4);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        chk("t5_err_cleared", 64'(err), 64'(0));

        // Mid-row reset discards the partial word
        send(55, 0); send(66, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        send(10, 0); send(20, 0); send(30, 0); send(40, 1);
        expect_word("t6", 32'h281E140A, 1'b1);
        idle(2);

        // Randomized rows
        rand_rdy = 1'b1;
        for (int r = 0; r < 60; r++) begin
            shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            relu  = 1'($urandom_range(0, 1));
            len   = $urandom_range(1, LENROW);
            for (int e = 0; e < len; e++) begin
                glb_rdy = 1'($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) == 0) idle(1);
                if ($urandom_range(0, 1) == 0) send($urandom_range(0, 1200) - 600, e == len - 1);
                else send(int'($signed(20'($urandom))), e == len - 1);
            end
        end
        rand_rdy = 1'b0;
        glb_rdy  = 1'b1;
        idle(10);
        chk("final_empty", 64'(exp_q.size()), 64'(0));
        chk("final_vld", 64'(glb_vld), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
